ct_spsram_512x96_ctrl: RTL and testbench

Initiator-side access controller for the 512x96 single-port SRAM macro. It converts a valid/ready request stream (read or masked write) into the macro's active-low CEN/GWEN/WEN pin protocol. Read data returning one cycle after the access is captured into a 2-entry response FIFO with valid/ready backpressure. It sits between an L2/IFU-side requester and the SRAM wrapper, and can optionally zero-fill the array after reset.

---
 rtl/ct_spsram_512x96_ctrl_if.sv | 28 ++
 rtl/ct_spsram_512x96_ctrl.sv | 143 ++++++++++++++
 tb/tb_ct_spsram_512x96_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_spsram_512x96_ctrl_if.sv
// Request/response bundle between the requester and the SRAM access controller.
// master = requester side, slave = controller side.
interface ct_spsram_512x96_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr,
    output req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr,
    input  req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_spsram_512x96_ctrl.sv
// 512x96 single-port SRAM access controller with 2-entry read response FIFO.
// Define CT_SPSRAM_CTRL_INIT_EN to zero-fill the array after every reset.
module ct_spsram_512x96_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 512
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  ct_spsram_512x96_ctrl_if.slave bus,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  run;
  logic                  init_act;
  logic [ADDR_WIDTH-1:0] init_a;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] icnt_q, icnt_d;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= S_INIT;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    if (state_q == S_INIT) begin
      icnt_d = icnt_q + ADDR_WIDTH'(1);
      if (icnt_q == ADDR_WIDTH'(DEPTH - 1))
        state_d = S_RUN;
    end
  end

  assign run       = (state_q == S_RUN);
  assign init_act  = (state_q == S_INIT) && cpurst_b;
  assign init_a    = icnt_q;
  assign init_done = run;
`else
  assign run       = 1'b1;
  assign init_act  = 1'b0;
  assign init_a    = '0;
  assign init_done = 1'b1;
`endif

  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wp_q, wp_d;
  logic                  rp_q, rp_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];

  logic                  rdy;
  logic                  rsp_vld;
  logic                  push, pop, rd_acc;
  logic [2:0]            occ;

  assign rsp_vld       = (cnt_q != 2'd0);
  assign pop           = rsp_vld && bus.rsp_rdy;
  assign push          = rd_pend_q;
  assign rd_acc        = bus.req_vld && rdy && !bus.req_wr;
  assign bus.req_rdy   = rdy;
  assign bus.rsp_vld   = rsp_vld;
  assign bus.rsp_rdata = fifo_q[rp_q];

  // Slots committed after this cycle; rsp_rdy feeds req_rdy on purpose.
  assign occ = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};

  always_comb begin
    rdy       = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = bus.req_addr;
    sram_d    = bus.req_wdata;
    if (init_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_a;
      sram_d    = '0;
    end else if (run && cpurst_b) begin
      rdy = bus.req_wr || (occ < 3'd2);
      if (bus.req_vld && rdy) begin
        sram_cen  = 1'b0;
        sram_gwen = ~bus.req_wr;
        sram_wen  = bus.req_wr ? ~bus.req_wmask : '1;
      end
    end
  end

  always_comb begin
    rd_pend_d = rd_acc;
    wp_d      = wp_q ^ push;
    rp_d      = rp_q ^ pop;
    cnt_d     = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 2'd1;
    else if (!push && pop)
      cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      rd_pend_q <= 1'b0;
      cnt_q     <= 2'd0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      if (push)
        fifo_q[wp_q] <= sram_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b) begin
      assert (!(pop && cnt_q == 2'd0));
      assert (!(push && !pop && cnt_q == 2'd2));
      assert (DEPTH == (1 << ADDR_WIDTH));
    end
  end

endmodule

// File: tb/tb_ct_spsram_512x96_ctrl.sv
// Directed bench for ct_spsram_512x96_ctrl with a behavioural SRAM macro.
// Covers both CT_SPSRAM_CTRL_INIT_EN builds.
module tb_ct_spsram_512x96_ctrl;
  localparam int AW = 9;
  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ct_spsram_512x96_ctrl_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  ct_spsram_512x96_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(512)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .bus           (bus),
    .init_done     (init_done),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_a        (sram_a),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  // Behavioural macro: bit-masked write, registered read.
  logic [DW-1:0] mem [512];
  logic [DW-1:0] q_q;
  assign sram_q = q_q;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen)
                     | (sram_d & ~sram_wen);
      else
        q_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [DW-1:0] dat,
                    input logic [DW-1:0] m);
    bus.req_vld   = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = dat;
    bus.req_wmask = m;
    settle();
    chk("wr_rdy", DW'(bus.req_rdy), DW'(1));
    chk("wr_cen", DW'(sram_cen), DW'(0));
    chk("wr_gwen", DW'(sram_gwen), DW'(0));
    chk("wr_wen", sram_wen, ~m);
    chk("wr_a", DW'(sram_a), DW'(a));
    cyc();
    bus.req_vld = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    input logic [DW-1:0] exp);
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = a;
    settle();
    chk("rd_rdy", DW'(bus.req_rdy), DW'(1));
    chk("rd_cen", DW'(sram_cen), DW'(0));
    chk("rd_gwen", DW'(sram_gwen), DW'(1));
    chk("rd_wen", sram_wen, {DW{1'b1}});
    cyc();
    bus.req_vld = 1'b0;
    settle();
    chk("rd_t1_vld", DW'(bus.rsp_vld), DW'(0));
    cyc();
    settle();
    chk("rd_t2_vld", DW'(bus.rsp_vld), DW'(1));
    chk("rd_t2_data", bus.rsp_rdata, exp);
    cyc();
    settle();
    chk("rd_t3_vld", DW'(bus.rsp_vld), DW'(0));
  endtask

  task automatic rdreq(input logic [AW-1:0] a);
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = a;
  endtask

  logic [DW-1:0] a5;
  logic [DW-1:0] ones;

  initial begin
    a5   = {12{8'hA5}};
    ones = {DW{1'b1}};
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.rsp_rdy   = 1'b1;

    // reset held
    cyc(); cyc(); cyc();
    bus.req_vld = 1'b1;
    settle();
    chk("rst_rdy", DW'(bus.req_rdy), DW'(0));
    chk("rst_cen", DW'(sram_cen), DW'(1));
    chk("rst_gwen", DW'(sram_gwen), DW'(1));
    chk("rst_wen", sram_wen, ones);
    chk("rst_vld", DW'(bus.rsp_vld), DW'(0));
    chk("rst_data", bus.rsp_rdata, '0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
    chk("rst_done", DW'(init_done), DW'(0));
`else
    chk("rst_done", DW'(init_done), DW'(1));
`endif
    bus.req_vld = 1'b0;
    bus.req_wr  = 1'b0;

    // release: cycle 1
    rst_n = 1'b1;
    settle();
`ifdef CT_SPSRAM_CTRL_INIT_EN
    for (int i = 0; i < 512; i++) begin
      chk("init_a", DW'(sram_a), DW'(i));
      chk("init_cen", DW'(sram_cen), DW'(0));
      chk("init_d", sram_d, '0);
      chk("init_wen", sram_wen, '0);
      chk("init_done0", DW'(init_done), DW'(0));
      chk("init_rdy", DW'(bus.req_rdy), DW'(0));
      cyc();
      settle();
    end
    chk("init_done513", DW'(init_done), DW'(1));
    chk("init_rdy513", DW'(bus.req_rdy), DW'(1));
    rd(9'h1FF, '0);
`else
    chk("c1_done", DW'(init_done), DW'(1));
    chk("c1_rdy", DW'(bus.req_rdy), DW'(1));
`endif

    // single write / read, partial mask
    wr(9'h1AB, DW'(1), ones);
    rd(9'h1AB, DW'(1));
    wr(9'h005, a5, ones);
    rd(9'h005, a5);
    wr(9'h010, ones, ones);
    wr(9'h010, '0, DW'(48'hFFFF_FFFF_FFFF));
    rd(9'h010, {48'hFFFF_FFFF_FFFF, 48'h0});

    for (int i = 1; i <= 4; i++)
      wr(AW'(i), DW'(i), ones);

    // four back-to-back reads, no backpressure
    for (int i = 0; i < 6; i++) begin
      if (i < 4) rdreq(AW'(i + 1));
      else bus.req_vld = 1'b0;
      settle();
      if (i < 4) chk("b2b_rdy", DW'(bus.req_rdy), DW'(1));
      chk("b2b_vld", DW'(bus.rsp_vld), DW'(i >= 2));
      if (i >= 2) chk("b2b_data", bus.rsp_rdata, DW'(i - 1));
      cyc();
    end
    settle();
    chk("b2b_empty", DW'(bus.rsp_vld), DW'(0));

    // backpressure: two reads fill the FIFO
    bus.rsp_rdy = 1'b0;
    rdreq(9'h001); settle();
    chk("bp_rdy_t0", DW'(bus.req_rdy), DW'(1));
    cyc();
    rdreq(9'h002); settle();
    chk("bp_rdy_t1", DW'(bus.req_rdy), DW'(1));
    cyc();
    rdreq(9'h003); settle();
    chk("bp_rdy_t2", DW'(bus.req_rdy), DW'(0));
    chk("bp_vld_t2", DW'(bus.rsp_vld), DW'(1));
    chk("bp_data_t2", bus.rsp_rdata, DW'(1));
    bus.req_vld = 1'b0;
    bus.req_wr  = 1'b1;
    settle();
    chk("bp_wr_rdy", DW'(bus.req_rdy), DW'(1));
    bus.req_wr  = 1'b0;
    bus.req_vld = 1'b1;
    settle();
    cyc();
    settle();
    chk("bp_rdy_t3", DW'(bus.req_rdy), DW'(0));
    chk("bp_data_t3", bus.rsp_rdata, DW'(1));
    cyc();
    bus.rsp_rdy = 1'b1;
    settle();
    chk("bp_rdy_t4", DW'(bus.req_rdy), DW'(1));
    chk("bp_data_t4", bus.rsp_rdata, DW'(1));
    cyc();
    rdreq(9'h004); settle();
    chk("bp_rdy_t5", DW'(bus.req_rdy), DW'(1));
    chk("bp_data_t5", bus.rsp_rdata, DW'(2));
    cyc();
    bus.req_vld = 1'b0; settle();
    chk("bp_vld_t6", DW'(bus.rsp_vld), DW'(1));
    chk("bp_data_t6", bus.rsp_rdata, DW'(3));
    cyc(); settle();
    chk("bp_vld_t7", DW'(bus.rsp_vld), DW'(1));
    chk("bp_data_t7", bus.rsp_rdata, DW'(4));
    cyc(); settle();
    chk("bp_vld_t8", DW'(bus.rsp_vld), DW'(0));

    // reset with one entry held and a read pending
    bus.rsp_rdy = 1'b0;
    rdreq(9'h001); cyc();
    rdreq(9'h002); cyc();
    bus.req_vld = 1'b0;
    settle();
    chk("mr_vld_pre", DW'(bus.rsp_vld), DW'(1));
    rst_n = 1'b0;
    bus.req_wr = 1'b1;
    settle();
    chk("mr_rdy", DW'(bus.req_rdy), DW'(0));
    chk("mr_cen", DW'(sram_cen), DW'(1));
    bus.req_wr = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.rsp_rdy = 1'b1;
    settle();
    chk("mr_vld", DW'(bus.rsp_vld), DW'(0));
    chk("mr_data", bus.rsp_rdata, '0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
    chk("mr_done", DW'(init_done), DW'(0));
    chk("mr_a", DW'(sram_a), DW'(0));
    chk("mr_icen", DW'(sram_cen), DW'(0));
    for (int i = 0; i < 512; i++) begin
      chk("mr_stale", DW'(bus.rsp_vld), DW'(0));
      cyc();
      settle();
    end
    chk("mr_done513", DW'(init_done), DW'(1));
    rd(9'h005, '0);
`else
    chk("mr_done", DW'(init_done), DW'(1));
    chk("mr_rdy1", DW'(bus.req_rdy), DW'(1));
    for (int i = 0; i < 4; i++) begin
      chk("mr_stale", DW'(bus.rsp_vld), DW'(0));
      cyc();
      settle();
    end
    rd(9'h005, a5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
